// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT stage sequencer: state
// encodings, default sizes and constant helpers used for counter sizing.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_e;

  // Default transform size and its butterfly count per stage.
  localparam int FFT_N_LOG2_DEF = 4;
  localparam int FFT_HALF_N_DEF = 1 << (FFT_N_LOG2_DEF - 1);

  // Ceiling log2 for sizing counters from elaboration-time constants.
  function automatic int fft_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Number of butterflies per stage (N/2) for a given log2 length.
  function automatic int fft_half_n(input int n_log2);
    return 1 << (n_log2 - 1);
  endfunction

endpackage

// File: rtl/ring_shift_register.sv
// Rotating shift register with a configurable reset value. Rotates one
// position per enabled clock, left (towards the MSB) or right.
module ring_shift_register #(
  parameter int BITNESS     = 4,
  parameter bit shLeft      = 1'b1,
  parameter int RESET_VALUE = 1,
  parameter bit synch_RESET = 1'b0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  output logic [BITNESS-1:0] OUT
);

  localparam logic [BITNESS-1:0] RV = BITNESS'(RESET_VALUE);

  logic [BITNESS-1:0] ring_d;
  logic [BITNESS-1:0] ring_q;

  // Next ring value: rotate by one when enabled, otherwise hold.
  always_comb begin
    ring_d = ring_q;
    if (EN) begin
      if (shLeft) begin
        ring_d = {ring_q[BITNESS-2:0], ring_q[BITNESS-1]};
      end else begin
        ring_d = {ring_q[0], ring_q[BITNESS-1:1]};
      end
    end else begin
      ring_d = ring_q;
    end
  end

  generate
    if (synch_RESET) begin : g_sync_rst
      // Ring register with synchronous reset.
      always_ff @(posedge CLK) begin
        if (RST) begin
          ring_q <= RV;
        end else begin
          ring_q <= ring_d;
        end
      end
    end else begin : g_async_rst
      // Ring register with asynchronous reset.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          ring_q <= RV;
        end else begin
          ring_q <= ring_d;
        end
      end
    end
  endgenerate

  assign OUT = ring_q;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Issue sequencer for an iterative radix-2 DIT FFT. Walks N_LOG2 stages of
// N/2 butterflies, one issue per cycle, with a PIPE_LAT-cycle flush gap after
// each stage so in-place writes land before the next stage reads.
// Optional feature macro: FFT_SEQ_INVERSE_EN (adds INVERSE / o_TW_CONJ).
// All outputs are registered; the address/twiddle registers are loaded from
// the next-state counters so they line up with the state they describe.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2   = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              START,
  input  logic              STALL,
`ifdef FFT_SEQ_INVERSE_EN
  input  logic              INVERSE,
  output logic              o_TW_CONJ,
`endif
  output logic              o_BUSY,
  output logic              o_VALID,
  output logic [N_LOG2-1:0] o_ADDR_A,
  output logic [N_LOG2-1:0] o_ADDR_B,
  output logic [N_LOG2-2:0] o_TW_IDX,
  output logic [N_LOG2-1:0] o_STAGE_OH,
  output logic              o_DONE
);

  localparam int HALF_N = fft_half_n(N_LOG2);
  localparam int KW     = N_LOG2 - 1;
  localparam int SW     = (N_LOG2 <= 2) ? 1 : fft_clog2(N_LOG2);
  localparam int FW     = (PIPE_LAT <= 2) ? 1 : fft_clog2(PIPE_LAT);

  localparam logic [KW-1:0]     LAST_K = KW'(HALF_N - 1);
  localparam logic [SW-1:0]     LAST_S = SW'(N_LOG2 - 1);
  localparam logic [FW-1:0]     LAST_F = FW'(PIPE_LAT - 1);
  localparam logic [N_LOG2-1:0] ONE_N  = N_LOG2'(1);

  fft_state_e  state_d, state_q;
  logic [SW-1:0] s_d, s_q;
  logic [KW-1:0] k_d, k_q;
  logic [FW-1:0] flush_d, flush_q;
  logic          adv_s;

  logic [N_LOG2-1:0] span_s, pos_s, grp_s, tw_full_s;
  logic [N_LOG2-1:0] addr_a_d, addr_b_d;
  logic [N_LOG2-2:0] tw_d;

  logic              busy_q, valid_q, done_q;
  logic [N_LOG2-1:0] addr_a_q, addr_b_q;
  logic [N_LOG2-2:0] tw_q;

`ifdef FFT_SEQ_INVERSE_EN
  logic inv_d, inv_q, conj_q;
`endif

  // Control path: state transitions, butterfly/stage/flush counters and the
  // stage-advance strobe that also rotates the one-hot stage register.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    flush_d = flush_q;
    adv_s   = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          s_d     = '0;
          k_d     = '0;
          flush_d = '0;
`ifdef FFT_SEQ_INVERSE_EN
          inv_d   = INVERSE;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!STALL) begin
          if (k_q == LAST_K) begin
            k_d = '0;
            if (PIPE_LAT == 0) begin
              adv_s = 1'b1;
            end else begin
              state_d = ST_FLUSH;
              flush_d = '0;
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end else begin
          k_d = k_q;
        end
      end
      ST_FLUSH: begin
        if (flush_q == LAST_F) begin
          flush_d = '0;
          adv_s   = 1'b1;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (adv_s) begin
      if (s_q == LAST_S) begin
        s_d     = '0;
        state_d = ST_DONE;
      end else begin
        s_d     = s_q + SW'(1);
        state_d = ST_RUN;
      end
    end else begin
      s_d = s_d;
    end
  end

  // Butterfly address and twiddle index for the upcoming cycle, zero when the
  // upcoming cycle is not an issue.
  always_comb begin
    span_s    = ONE_N << s_d;
    pos_s     = {1'b0, k_d} & (span_s - ONE_N);
    grp_s     = {1'b0, k_d} >> s_d;
    tw_full_s = pos_s << (N_LOG2 - 1 - int'(s_d));
    if (state_d == ST_RUN) begin
      addr_a_d = (grp_s << (int'(s_d) + 1)) | pos_s;
      addr_b_d = addr_a_d + span_s;
      tw_d     = tw_full_s[N_LOG2-2:0];
    end else begin
      addr_a_d = '0;
      addr_b_d = '0;
      tw_d     = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      k_q      <= '0;
      flush_q  <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
`ifdef FFT_SEQ_INVERSE_EN
      inv_q    <= 1'b0;
      conj_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      k_q      <= k_d;
      flush_q  <= flush_d;
      busy_q   <= (state_d != ST_IDLE);
      valid_q  <= (state_d == ST_RUN);
      done_q   <= (state_d == ST_DONE);
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
`ifdef FFT_SEQ_INVERSE_EN
      inv_q    <= inv_d;
      conj_q   <= inv_d & (state_d == ST_RUN);
`endif
    end
  end

  // One-hot stage select, rotated on every stage advance (wraps to bit 0
  // when the last stage completes).
  ring_shift_register #(
    .BITNESS    (N_LOG2),
    .shLeft     (1'b1),
    .RESET_VALUE(1),
    .synch_RESET(1'b0)
  ) u_stage_ring (
    .CLK(CLK),
    .RST(~nRST),
    .EN (adv_s),
    .OUT(o_STAGE_OH)
  );

  assign o_BUSY   = busy_q;
  assign o_VALID  = valid_q;
  assign o_ADDR_A = addr_a_q;
  assign o_ADDR_B = addr_b_q;
  assign o_TW_IDX = tw_q;
  assign o_DONE   = done_q;
`ifdef FFT_SEQ_INVERSE_EN
  assign o_TW_CONJ = conj_q;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer. A reference model builds the
// expected per-cycle output sequence of a whole transform from the butterfly
// pairing rule (pairs a / a+span with bit s of a clear, in ascending a),
// then replays it against the DUT, repeating an issue while it is stalled.
module tb_fft_stage_sequencer;

  localparam int NL = 4;
  localparam int PL = 3;
  localparam int N  = 16;
  localparam int HN = 8;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic START = 1'b0;
  logic STALL = 1'b0;
  logic INVERSE = 1'b0;
  logic START0 = 1'b0;
  logic STALL0 = 1'b0;

  logic          o_BUSY, o_VALID, o_DONE;
  logic [NL-1:0] o_ADDR_A, o_ADDR_B, o_STAGE_OH;
  logic [NL-2:0] o_TW_IDX;
  logic          o_TW_CONJ;

  logic          o_BUSY0, o_VALID0, o_DONE0;
  logic [NL-1:0] o_ADDR_A0, o_ADDR_B0, o_STAGE_OH0;
  logic [NL-2:0] o_TW_IDX0;
  logic          o_TW_CONJ0;

  always #5 CLK = ~CLK;

  fft_stage_sequencer #(.N_LOG2(NL), .PIPE_LAT(PL)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .STALL(STALL),
`ifdef FFT_SEQ_INVERSE_EN
    .INVERSE(INVERSE), .o_TW_CONJ(o_TW_CONJ),
`endif
    .o_BUSY(o_BUSY), .o_VALID(o_VALID), .o_ADDR_A(o_ADDR_A), .o_ADDR_B(o_ADDR_B),
    .o_TW_IDX(o_TW_IDX), .o_STAGE_OH(o_STAGE_OH), .o_DONE(o_DONE)
  );

  fft_stage_sequencer #(.N_LOG2(NL), .PIPE_LAT(0)) dut0 (
    .CLK(CLK), .nRST(nRST), .START(START0), .STALL(STALL0),
`ifdef FFT_SEQ_INVERSE_EN
    .INVERSE(1'b0), .o_TW_CONJ(o_TW_CONJ0),
`endif
    .o_BUSY(o_BUSY0), .o_VALID(o_VALID0), .o_ADDR_A(o_ADDR_A0), .o_ADDR_B(o_ADDR_B0),
    .o_TW_IDX(o_TW_IDX0), .o_STAGE_OH(o_STAGE_OH0), .o_DONE(o_DONE0)
  );

  typedef struct {
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
    logic [3:0] oh;
    logic       dn;
    logic       cj;
  } rec_t;

  rec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   since = 0;
  int   done_cyc = -1;
  int   acc = 0;
  bit   track = 1'b0;
  logic smp_valid = 1'b0;

  // Single comparison point: count it, report a mismatch.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Expected cycle sequence of one whole transform, started with inverse flag inv.
  task automatic build_q(input logic inv);
    rec_t r;
    int   span;
    for (int s = 0; s < NL; s++) begin
      span = 1 << s;
      for (int a = 0; a < N; a++) begin
        if (((a >> s) & 1) == 0) begin
          r.v  = 1'b1;
          r.a  = 4'(a);
          r.b  = 4'(a + span);
          r.tw = 3'((a % span) * (HN / span));
          r.oh = 4'(1 << s);
          r.dn = 1'b0;
          r.cj = inv;
          exp_q.push_back(r);
        end
      end
      for (int f = 0; f < PL; f++) begin
        r.v = 1'b0; r.a = 4'd0; r.b = 4'd0; r.tw = 3'd0;
        r.oh = 4'(1 << s); r.dn = 1'b0; r.cj = 1'b0;
        exp_q.push_back(r);
      end
    end
    r.v = 1'b0; r.a = 4'd0; r.b = 4'd0; r.tw = 3'd0;
    r.oh = 4'd1; r.dn = 1'b1; r.cj = 1'b0;
    exp_q.push_back(r);
  endtask

  // Sample at the falling edge and compare against the model's current cycle.
  task automatic tick();
    rec_t e;
    logic busy_e;
    @(negedge CLK);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      busy_e = 1'b1;
    end else begin
      e.v = 1'b0; e.a = 4'd0; e.b = 4'd0; e.tw = 3'd0;
      e.oh = 4'd1; e.dn = 1'b0; e.cj = 1'b0;
      busy_e = 1'b0;
    end
    check_val("busy", o_BUSY, busy_e);
    check_val("valid", o_VALID, e.v);
    check_val("addr_a", o_ADDR_A, e.a);
    check_val("addr_b", o_ADDR_B, e.b);
    check_val("tw_idx", o_TW_IDX, e.tw);
    check_val("stage_oh", o_STAGE_OH, e.oh);
    check_val("done", o_DONE, e.dn);
`ifdef FFT_SEQ_INVERSE_EN
    check_val("tw_conj", o_TW_CONJ, e.cj);
`endif
    smp_valid = o_VALID;
    if (track) begin
      since++;
      if (o_DONE) begin
        done_cyc = since;
        track = 1'b0;
      end
    end
  endtask

  // Drive inputs for the coming edge and advance the model accordingly.
  task automatic drive(input logic st, input logic stl, input logic inv);
    START = st;
    STALL = stl;
    INVERSE = inv;
    if (exp_q.size() == 0) begin
      if (st) begin
        build_q(inv);
        track = 1'b1;
        since = 0;
        acc = 0;
        done_cyc = -1;
      end
    end else begin
      if (smp_valid && !stl) acc++;
      if (!(exp_q[0].v && stl)) void'(exp_q.pop_front());
    end
  endtask

  int done0 = -1;
  int v0 = 0;
  int gap0 = 0;

  initial begin
    // Power-on reset.
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b0, 1'b0, 1'b0);
    end
    nRST = 1'b1;

    // Plain run, no stall.
    tick();
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 300 && track; c++) begin
      tick();
      if (since == 1) begin
        check_val("first_a", o_ADDR_A, 0);
        check_val("first_b", o_ADDR_B, 1);
      end
      if (since == 12) check_val("oh_stage1", o_STAGE_OH, 4'b0010);
      if (since == 15) begin
        check_val("s1k3_a", o_ADDR_A, 5);
        check_val("s1k3_b", o_ADDR_B, 7);
        check_val("s1k3_tw", o_TW_IDX, 4);
      end
      if (since == 41) begin
        check_val("s3k7_a", o_ADDR_A, 7);
        check_val("s3k7_b", o_ADDR_B, 15);
        check_val("s3k7_tw", o_TW_IDX, 7);
      end
      drive(1'b0, 1'b0, 1'b0);
    end
    check_val("run_timeout", track, 0);
    check_val("done_cycle", done_cyc, 45);
    check_val("issues", acc, 32);

    // Stall five cycles at s=2,k=2.
    tick();
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 300 && track; c++) begin
      tick();
      if (since >= 25 && since <= 30) begin
        check_val("stall_valid", o_VALID, 1);
        check_val("stall_a", o_ADDR_A, 2);
        check_val("stall_b", o_ADDR_B, 6);
        check_val("stall_tw", o_TW_IDX, 4);
      end
      drive(1'b0, (since >= 25 && since <= 29), 1'b0);
    end
    check_val("stall_timeout", track, 0);
    check_val("stall_done_cycle", done_cyc, 50);
    check_val("stall_issues", acc, 32);

    // START held high while busy and in the DONE cycle: ignored.
    tick();
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 300 && track; c++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0);
    end
    check_val("pester_done_cycle", done_cyc, 45);
    tick();
    check_val("start_in_done_ignored", o_BUSY, 0);
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 300 && track; c++) begin
      tick();
      drive(1'b0, 1'b0, 1'b0);
    end
    check_val("restart_done_cycle", done_cyc, 45);

    // Reset in the middle of a transform.
    tick();
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      tick();
      drive(1'b0, 1'b0, 1'b0);
    end
    tick();
    nRST = 1'b0;
    START = 1'b0;
    STALL = 1'b0;
    exp_q.delete();
    track = 1'b0;
    #1;
    check_val("rst_busy", o_BUSY, 0);
    check_val("rst_valid", o_VALID, 0);
    check_val("rst_oh", o_STAGE_OH, 4'b0001);
    check_val("rst_done", o_DONE, 0);
    tick();
    nRST = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 300 && track; c++) begin
      tick();
      if (since == 1) check_val("post_rst_tw", o_TW_IDX, 0);
      drive(1'b0, 1'b0, 1'b0);
    end
    check_val("post_rst_done_cycle", done_cyc, 45);

    // Randomized traffic: random START, STALL and INVERSE.
    for (int c = 0; c < 3000; c++) begin
      tick();
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    for (int c = 0; c < 500 && exp_q.size() > 0; c++) begin
      tick();
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    check_val("drain_empty", exp_q.size(), 0);

    // PIPE_LAT=0 instance: no flush gap, DONE in cycle 33.
    @(negedge CLK);
    START0 = 1'b1;
    @(negedge CLK);
    START0 = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (o_DONE0) begin
        done0 = c;
        break;
      end
      if (o_VALID0) v0++;
      else gap0++;
      @(negedge CLK);
    end
    check_val("lat0_done_cycle", done0, 33);
    check_val("lat0_issues", v0, 32);
    check_val("lat0_gaps", gap0, 0);
    check_val("lat0_oh", o_STAGE_OH0, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
